// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - RAM-driven square-wave melody player on clk12
// Entries {oct, rsv, semi, dur} play in address order until a dur=0 entry or the last address.
module melody_sequencer #(
  parameter int ADDR_W   = 5,
  parameter int DUR_W    = 4,
  parameter int TICK_CYC = 750000,
  parameter int GAP_CYC  = 60000
) (
  input  logic              clk12,
  input  logic              n_reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DUR_W+7:0]  wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              speaker
);
  localparam int TICK_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);
  localparam logic [TICK_W-1:0] GAP_START = TICK_W'(TICK_CYC - GAP_CYC - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_END   = 3'd5;

  logic [2:0]        state;
  logic [DUR_W+7:0]  mem [2**ADDR_W];
  logic [DUR_W+7:0]  rd_data;
  logic [DUR_W-1:0]  rd_dur;
  logic [DUR_W-1:0]  dur_left;
  logic [3:0]        rd_semi;
  logic [1:0]        rd_oct;
  logic [TICK_W-1:0] tick_cnt;
  logic [14:0]       half;
  logic [14:0]       tone_cnt;
  logic              note_end;
  logic              unused_rsv;

  // C4..B4 half-periods in clk12 cycles; 0 marks a rest
  function automatic logic [14:0] note_half(input logic [3:0] semi);
    case (semi)
      4'd1:    return 15'd22933;
      4'd2:    return 15'd21646;
      4'd3:    return 15'd20431;
      4'd4:    return 15'd19284;
      4'd5:    return 15'd18202;
      4'd6:    return 15'd17181;
      4'd7:    return 15'd16216;
      4'd8:    return 15'd15306;
      4'd9:    return 15'd14447;
      4'd10:   return 15'd13636;
      4'd11:   return 15'd12871;
      4'd12:   return 15'd12148;
      default: return 15'd0;
    endcase
  endfunction

  // Melody RAM keeps its contents across n_reset; power-up content is all zero.
  always_ff @(posedge clk12) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[cur_addr];
  end

  assign rd_dur     = rd_data[DUR_W-1:0];
  assign rd_semi    = rd_data[DUR_W+3:DUR_W];
  assign rd_oct     = rd_data[DUR_W+7:DUR_W+6];
  assign unused_rsv = ^rd_data[DUR_W+5:DUR_W+4];

  assign busy = (state != S_IDLE);

  // Last cycle of a note slot: end of GAP, or end of PLAY when there is no gap.
  assign note_end = (tick_cnt == TICK_LAST) &&
                    ((state == S_GAP) ||
                     (state == S_PLAY && GAP_CYC == 0 && dur_left == DUR_W'(1)));

  always_ff @(posedge clk12 or negedge n_reset) begin
    if (!n_reset) begin
      state    <= S_IDLE;
      cur_addr <= '0;
      speaker  <= 1'b0;
      done     <= 1'b0;
      dur_left <= '0;
      tick_cnt <= '0;
      tone_cnt <= '0;
      half     <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state   <= S_IDLE;
        speaker <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            speaker <= 1'b0;
            if (start) begin
              cur_addr <= '0;
              state    <= S_FETCH;
            end
          end
          S_FETCH: state <= S_LOAD;
          S_LOAD: begin
            if (rd_dur == '0) begin
              state <= S_END;
            end else begin
              dur_left <= rd_dur;
              tick_cnt <= '0;
              tone_cnt <= '0;
              speaker  <= 1'b0;
              half     <= note_half(rd_semi) >> rd_oct;
              state    <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              dur_left <= dur_left - DUR_W'(1);
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
            if (half != '0) begin
              if (tone_cnt == half - 15'd1) begin
                speaker  <= ~speaker;
                tone_cnt <= '0;
              end else begin
                tone_cnt <= tone_cnt + 15'd1;
              end
            end
            if (GAP_CYC != 0 && dur_left == DUR_W'(1) && tick_cnt == GAP_START) begin
              speaker <= 1'b0;
              state   <= S_GAP;
            end
          end
          S_GAP: begin
            speaker  <= 1'b0;
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_W'(1);
          end
          S_END: begin
            if (loop_en) begin
              cur_addr <= '0;
              state    <= S_FETCH;
            end else begin
              done  <= 1'b1;
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
        if (note_end) begin
          speaker <= 1'b0;
          if (cur_addr == LAST_ADDR) begin
            state <= S_END;
          end else begin
            cur_addr <= cur_addr + ADDR_W'(1);
            state    <= S_FETCH;
          end
        end
      end
    end
  end
endmodule
